// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the accumulator/stack CPU front end.
package cpu_isa_pkg;

    localparam int unsigned IR_W        = 16;
    localparam int unsigned OPCODE_W    = 5;
    localparam int unsigned IMM_W       = 10;
    localparam int unsigned INSTR_CNT_W = 16;

    // Instruction register field positions
    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 11;
    localparam int unsigned FLAG_BIT   = 10;
    localparam int unsigned IMM_MSB    = 9;
    localparam int unsigned IMM_LSB    = 0;

    // Opcode constants
    localparam logic [OPCODE_W-1:0] OP_APUT = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_SPUT = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_AADD = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_ASUB = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_SPEK = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_SPOP = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_RPOP = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_JIMM = 5'b00111;
    localparam logic [OPCODE_W-1:0] OP_JACC = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_JCMP = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_JFNC = 5'b01011;
    localparam logic [OPCODE_W-1:0] OP_LORR = 5'b01111;
    localparam logic [OPCODE_W-1:0] OP_LAND = 5'b10000;
    localparam logic [OPCODE_W-1:0] OP_BKAC = 5'b10101;
    localparam logic [OPCODE_W-1:0] OP_BKRA = 5'b10110;

    // Fetch/issue sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_e;

    // Decoded view of the instruction register
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic                flagbit;
        logic [IMM_W-1:0]    imm;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [IR_W-1:0] ir);
        return instr_fields_t'(ir);
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts instruction-memory wait cycles; flags when the budget is used up.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    // Wait-cycle counter: clear has priority over increment
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired_c = (r_count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue front end: fetch over req/valid, hold in IR, issue, advance PC.
module instr_fetch_issue
    import cpu_isa_pkg::*;
#(
    parameter int unsigned   AW       = 10,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int unsigned   TIMEOUT  = 15
) (
    input  logic                   CLK,
    input  logic                   RST,
    output logic                   imem_req,
    output logic [AW-1:0]          imem_addr,
    input  logic [IR_W-1:0]        imem_rdata,
    input  logic                   imem_valid,
    output logic [OPCODE_W-1:0]    OPCODE,
    output logic                   flagbit,
    output logic [IMM_W-1:0]       IMM,
    output logic                   instr_valid,
    input  logic                   exec_done,
    input  logic                   PCWrite,
    input  logic [AW-1:0]          pc_next,
    output logic [AW-1:0]          PC,
    output logic                   fetch_err,
    output logic [INSTR_CNT_W-1:0] instr_count
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [AW-1:0]          r_pc;
    logic [IR_W-1:0]        r_ir;
    logic [INSTR_CNT_W-1:0] r_instr_count;
    logic                   r_imem_req;
    logic                   r_instr_valid;
    logic                   r_fetch_err;

    logic                   w_load_ir;
    logic                   w_retire;
    logic                   w_set_err;
    logic                   w_tmo_clear;
    logic                   w_tmo_enable;
    logic                   w_tmo_expired;
    instr_fields_t          w_fields;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk         (CLK),
        .rst         (RST),
        .i_clear     (w_tmo_clear),
        .i_enable    (w_tmo_enable),
        .o_expired_c (w_tmo_expired)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        w_state_next = r_state;
        w_load_ir    = 1'b0;
        w_retire     = 1'b0;
        w_set_err    = 1'b0;
        w_tmo_clear  = 1'b0;
        w_tmo_enable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    w_load_ir    = 1'b1;
                    w_tmo_clear  = 1'b1;
                    w_state_next = ST_ISSUE;
                end else begin
                    w_tmo_enable = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    w_load_ir    = 1'b1;
                    w_tmo_clear  = 1'b1;
                    w_state_next = ST_ISSUE;
                end else if (w_tmo_expired) begin
                    w_set_err    = 1'b1;
                    w_state_next = ST_ERR;
                end else begin
                    w_tmo_enable = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (exec_done) begin
                    w_retire     = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            ST_ERR: begin
                w_state_next = ST_ERR;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // PC, IR, retire counter and error flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_instr_count <= '0;
            r_fetch_err   <= 1'b0;
        end else begin
            if (w_load_ir) begin
                r_ir <= imem_rdata;
            end
            if (w_retire) begin
                r_pc          <= PCWrite ? pc_next : r_pc + AW'(1);
                r_instr_count <= r_instr_count + INSTR_CNT_W'(1);
            end
            if (w_set_err) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    // Handshake outputs registered from the upcoming state
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            r_imem_req    <= (w_state_next == ST_FETCH) || (w_state_next == ST_WAIT);
            r_instr_valid <= (w_state_next == ST_ISSUE);
        end
    end

    assign w_fields    = split_instr(r_ir);
    assign OPCODE      = w_fields.opcode;
    assign flagbit     = w_fields.flagbit;
    assign IMM         = w_fields.imm;

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign PC          = r_pc;
    assign fetch_err   = r_fetch_err;
    assign instr_count = r_instr_count;

endmodule
